// File: rtl/adder_operand_sequencer.sv
// Streams two WIDTH-bit operands in as WORD-sized beats (LSW first), holds them
// on the prefix adder for ADD_CYCLES, then streams the captured sum back out.
//
// state  | meaning
// LOAD_A | accepting operand A beats (beat 0 also latches carry-in)
// LOAD_B | accepting operand B beats
// ADD    | operands held steady while the combinational adder settles
// SEND   | first cycle primes the output word register, then sum beats go out
module adder_operand_sequencer #(
  parameter int WIDTH      = 128,
  parameter int WORD       = 32,
  parameter int ADD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_data,
  input  logic             in_cin,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
  output logic             out_last,
  output logic             out_cout
);

  localparam int BEATS = WIDTH / WORD;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] ADD_LOAD  = CW'(ADD_CYCLES - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, ADD, SEND} state_t;

  state_t           state;
  logic [BW-1:0]    beat;
  logic [BW-1:0]    beat_nxt;
  logic [CW-1:0]    add_cnt;
  logic [WIDTH-1:0] result;
  logic             res_cout;

  assign beat_nxt = beat + 1'b1;

  // Gated by rst_n so the port reads 0 during reset yet 1 right after release.
  assign in_ready = rst_n && ((state == LOAD_A) || (state == LOAD_B));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      beat      <= '0;
      add_cnt   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      result    <= '0;
      res_cout  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_valid) begin
            op_a[int'(beat)*WORD +: WORD] <= in_data;
            if (beat == '0) op_cin <= in_cin;
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              state <= LOAD_B;
            end else begin
              beat <= beat_nxt;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            op_b[int'(beat)*WORD +: WORD] <= in_data;
            if (beat == LAST_BEAT) begin
              beat    <= '0;
              add_cnt <= ADD_LOAD;
              state   <= ADD;
            end else begin
              beat <= beat_nxt;
            end
          end
        end
        ADD: begin
          if (add_cnt == '0) begin
            result   <= add_s;
            res_cout <= add_cout;
            state    <= SEND;
          end else begin
            add_cnt <= add_cnt - 1'b1;
          end
        end
        SEND: begin
          if (!out_valid) begin
            // beat is 0 here and BEATS >= 2, so the first word is never last
            out_valid <= 1'b1;
            out_data  <= result[WORD-1:0];
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
              out_cout  <= 1'b0;
              beat      <= '0;
              state     <= LOAD_A;
            end else begin
              beat     <= beat_nxt;
              out_data <= result[int'(beat_nxt)*WORD +: WORD];
              out_last <= (beat_nxt == LAST_BEAT);
              out_cout <= (beat_nxt == LAST_BEAT) ? res_cout : 1'b0;
            end
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule
